// File: rtl/bus_pkt_tx_if.sv
// Payload input handshake and framed-word output of the packet transmitter.
// The transmitter takes the slave side; the upstream producer/consumer takes master.
interface bus_pkt_tx_if;
    logic [7:0]  payload_in;
    logic        payload_valid;
    logic        payload_ready;
    logic [15:0] data_out;
    logic        data_valid;

    modport master (
        output payload_in, payload_valid,
        input  payload_ready, data_out, data_valid
    );

    modport slave (
        input  payload_in, payload_valid,
        output payload_ready, data_out, data_valid
    );
endinterface

// File: rtl/bus_pkt_tx.sv
// Packet transmitter: buffers payload bytes and emits registered {HEADER, payload, seq} words.
// Defining BUS_PKT_TX_ERR_INJ_EN adds the inj_err port for header/sequence fault injection.
module bus_pkt_tx #(
    parameter logic [3:0] HEADER     = 4'hF,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
`ifdef BUS_PKT_TX_ERR_INJ_EN
    input  logic [1:0]         inj_err,
`endif
    bus_pkt_tx_if.slave        bus,
    output logic [3:0]         state_out,
    output logic [4:0]         fifo_level
);
    // state | meaning
    // IDLE  | no frame open, seq held at 0
    // FIRST | first word of a frame emitted (seq 0)
    // SEND  | subsequent word emitted, seq advancing
    // HOLD  | frame open but buffer ran dry; seq and data_out retained
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FIRST = 4'b0010,
        S_SEND  = 4'b0100,
        S_HOLD  = 4'b1000
    } state_t;

    // FIFO_DEPTH is a power of two, so the pointers wrap naturally
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t        state_r, state_nxt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    level_r;
    logic [3:0]    seq_r, seq_word, seq_adv, hdr;
    logic [15:0]   data_r;
    logic          valid_r, emit, push, fifo_empty, ready;

    assign fifo_empty = (level_r == 5'd0);
    assign ready      = !reset && (level_r != 5'(FIFO_DEPTH));
    assign push       = bus.payload_valid && ready;

`ifdef BUS_PKT_TX_ERR_INJ_EN
    assign hdr      = inj_err[0] ? ~HEADER : HEADER;
    assign seq_word = seq_r + {3'b000, inj_err[1]};
    assign seq_adv  = seq_r + 4'd1 + {3'b000, inj_err[1]};
`else
    assign hdr      = HEADER;
    assign seq_word = seq_r;
    assign seq_adv  = seq_r + 4'd1;
`endif

    always_comb begin
        state_nxt = state_r;
        emit      = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_nxt = S_FIRST;
                        emit      = 1'b1;
                    end
                end
                S_FIRST, S_SEND, S_HOLD: begin
                    if (!fifo_empty) begin
                        state_nxt = S_SEND;
                        emit      = 1'b1;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            data_r  <= 16'h0000;
            valid_r <= 1'b0;
            seq_r   <= 4'd0;
        end else begin
            state_r <= state_nxt;
            valid_r <= emit;
            if (emit) begin
                data_r <= {hdr, fifo_mem[rd_ptr], seq_word};
                seq_r  <= seq_adv;
            end else if (!enable) begin
                seq_r  <= 4'd0;
            end
        end
    end

    // Reset discards buffered payloads by clearing the pointers; storage itself is not reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.payload_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (emit) rd_ptr <= rd_ptr + AW'(1);
            case ({push, emit})
                2'b10:   level_r <= level_r + 5'd1;
                2'b01:   level_r <= level_r - 5'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    assign bus.payload_ready = ready;
    assign bus.data_out      = data_r;
    assign bus.data_valid    = valid_r;
    assign state_out         = state_r;
    assign fifo_level        = level_r;
endmodule

// File: tb/tb_bus_pkt_tx.sv
// Self-checking bench for bus_pkt_tx: queue-based frame model compared every cycle,
// plus directed scenarios with hand-computed words.
module tb_bus_pkt_tx;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable;
    logic [3:0] state_out;
    logic [4:0] fifo_level;
`ifdef BUS_PKT_TX_ERR_INJ_EN
    logic [1:0] inj_err;
`endif

    bus_pkt_tx_if bus ();

    bus_pkt_tx #(.HEADER(4'hF), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
`ifdef BUS_PKT_TX_ERR_INJ_EN
        .inj_err    (inj_err),
`endif
        .bus        (bus),
        .state_out  (state_out),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a frame is open while enable stays high; each edge with a buffered
    // payload emits the oldest one with the running sequence number.
    logic [7:0]  q[$];
    logic [15:0] m_data;
    logic        m_valid;
    logic [3:0]  m_state;
    logic [3:0]  m_seq;
    bit          m_open;
    bit          m_push;
    logic [7:0]  m_pin;
    logic [3:0]  m_hdr;
    logic [3:0]  m_sw;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_data  = 16'h0000;
            m_valid = 1'b0;
            m_state = 4'b0001;
            m_seq   = 4'd0;
            m_open  = 1'b0;
        end else begin
            m_push = bus.payload_valid && (q.size() < FIFO_DEPTH);
            m_pin  = bus.payload_in;
            m_hdr  = 4'hF;
            m_sw   = m_seq;
`ifdef BUS_PKT_TX_ERR_INJ_EN
            if (inj_err[0]) m_hdr = 4'h0;
            if (inj_err[1]) m_sw = m_seq + 4'd1;
`endif
            if (!enable) begin
                m_valid = 1'b0;
                m_state = 4'b0001;
                m_seq   = 4'd0;
                m_open  = 1'b0;
            end else if (q.size() > 0) begin
                m_data  = {m_hdr, q.pop_front(), m_sw};
                m_seq   = m_sw + 4'd1;
                m_valid = 1'b1;
                m_state = m_open ? 4'b0100 : 4'b0010;
                m_open  = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_state = m_open ? 4'b1000 : 4'b0001;
            end
            if (m_push) q.push_back(m_pin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out",      bus.data_out, m_data);
            chk("data_valid",    16'(bus.data_valid), 16'(m_valid));
            chk("state_out",     16'(state_out), 16'(m_state));
            chk("fifo_level",    16'(fifo_level), 16'(q.size()));
            chk("payload_ready", 16'(bus.payload_ready),
                16'(!reset && (q.size() < FIFO_DEPTH)));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        enable            = 1'b0;
        bus.payload_in    = 8'h00;
        bus.payload_valid = 1'b0;
`ifdef BUS_PKT_TX_ERR_INJ_EN
        inj_err = 2'b00;
`endif
        #1 reset = 1'b1;
        #1;
        chk("rst_data",  bus.data_out, 16'h0000);
        chk("rst_valid", 16'(bus.data_valid), 16'h0);
        chk("rst_state", 16'(state_out), 16'h1);
        chk("rst_level", 16'(fifo_level), 16'h0);
        chk("rst_ready", 16'(bus.payload_ready), 16'h0);
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        #1 chk("ready_after_rst", 16'(bus.payload_ready), 16'h1);

        // Four consecutive payloads into a fresh frame
        enable = 1'b1; bus.payload_valid = 1'b1; bus.payload_in = 8'hBA;
        step(); bus.payload_in = 8'h0A;
        step();
        chk("w0_data",  bus.data_out, 16'hFBA0);
        chk("w0_valid", 16'(bus.data_valid), 16'h1);
        chk("w0_state", 16'(state_out), 16'h2);
        bus.payload_in = 8'h10;
        step(); chk("w1_data", bus.data_out, 16'hF0A1);
        bus.payload_in = 8'h1F;
        step(); chk("w2_data", bus.data_out, 16'hF102);
        bus.payload_valid = 1'b0;
        step(); chk("w3_data", bus.data_out, 16'hF1F3);
        step();
        chk("hold_state", 16'(state_out), 16'h8);
        chk("hold_valid", 16'(bus.data_valid), 16'h0);
        chk("hold_data",  bus.data_out, 16'hF1F3);

        // 17 words: sequence wraps F -> 0 inside SEND
        enable = 1'b0;
        step();
        chk("idle_state", 16'(state_out), 16'h1);
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.payload_valid = 1'b1; bus.payload_in = 8'h55;
            step();
        end
        chk("seqF_data", bus.data_out, 16'hF55F);
        bus.payload_valid = 1'b0;
        step();
        chk("wrap_data",  bus.data_out, 16'hF550);
        chk("wrap_state", 16'(state_out), 16'h4);

        // Fill while disabled, then drain one frame
        enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.payload_valid = 1'b1; bus.payload_in = 8'(8'h30 + i);
            step();
        end
        chk("full_level", 16'(fifo_level), 16'h4);
        chk("full_ready", 16'(bus.payload_ready), 16'h0);
        chk("full_idle",  16'(state_out), 16'h1);
        bus.payload_valid = 1'b0;
        enable = 1'b1;
        step(); chk("d0_data", bus.data_out, 16'hF300);
        step(); chk("d1_data", bus.data_out, 16'hF311);
        step(); chk("d2_data", bus.data_out, 16'hF322);
        step(); chk("d3_data", bus.data_out, 16'hF333);
        step();
        chk("d_hold_state", 16'(state_out), 16'h8);
        chk("d_hold_valid", 16'(bus.data_valid), 16'h0);

        // Reset asserted between edges while a frame is running
        enable = 1'b0;
        step();
        enable = 1'b1;
        bus.payload_valid = 1'b1; bus.payload_in = 8'h61;
        step(); bus.payload_in = 8'h62;
        step(); bus.payload_in = 8'h63;
        step();
        #2;
        reset = 1'b1;
        bus.payload_valid = 1'b0;
        #1;
        chk("mid_rst_data",  bus.data_out, 16'h0000);
        chk("mid_rst_valid", 16'(bus.data_valid), 16'h0);
        chk("mid_rst_state", 16'(state_out), 16'h1);
        chk("mid_rst_level", 16'(fifo_level), 16'h0);
        chk("mid_rst_ready", 16'(bus.payload_ready), 16'h0);
        step();
        reset = 1'b0;
        bus.payload_valid = 1'b1; bus.payload_in = 8'hA5;
        step();
        bus.payload_valid = 1'b0;
        step();
        chk("post_rst_data",  bus.data_out, 16'hFA50);
        chk("post_rst_state", 16'(state_out), 16'h2);

`ifdef BUS_PKT_TX_ERR_INJ_EN
        enable = 1'b0;
        step();
        enable = 1'b1;
        bus.payload_valid = 1'b1; bus.payload_in = 8'h00;
        step(); bus.payload_in = 8'h11;
        step(); bus.payload_in = 8'h22;
        step(); bus.payload_in = 8'hC9;
        step(); bus.payload_in = 8'hE4; inj_err = 2'b01;
        step();
        chk("inj_hdr_data", bus.data_out, 16'h0C93);
        bus.payload_valid = 1'b0; inj_err = 2'b10;
        step();
        chk("inj_seq_data", bus.data_out, 16'hFE45);
        inj_err = 2'b00; bus.payload_valid = 1'b1; bus.payload_in = 8'h77;
        step();
        bus.payload_valid = 1'b0;
        step();
        chk("inj_next_data", bus.data_out, 16'hF776);
`endif

        // Mixed enable/valid pattern, including pushes against a full buffer
        for (int i = 0; i < 40; i++) begin
            enable            = ((i % 11) != 10);
            bus.payload_valid = ((i % 3) != 2);
            bus.payload_in    = 8'(i * 7);
            step();
        end
        bus.payload_valid = 1'b0;
        enable = 1'b1;
        repeat (6) step();
        chk("drain_level", 16'(fifo_level), 16'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bus_pkt_tx.md
BUS_PKT_TX -- requirements
Module: bus_pkt_tx

Interface
REQ-001 Parameter HEADER, default 4'hF, header nibble placed in bits [15:12] of every emitted word.
REQ-002 Parameter FIFO_DEPTH, default 4, payload buffer depth; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high permits transmission; low ends the current frame.
REQ-006 payload_in  input  8  payload byte to be framed.
REQ-007 payload_valid  input  1  payload_in is offered this cycle.
REQ-008 payload_ready  output  1  buffer can accept; a transfer occurs on a rising edge with valid and ready both high.
REQ-009 data_out  output  16  framed word {HEADER, payload[7:0], seq[3:0]}, registered.
REQ-010 data_valid  output  1  data_out carries a new word this cycle, registered.
REQ-011 state_out  output  4  one-hot FSM state: IDLE=0001, FIRST=0010, SEND=0100, HOLD=1000.
REQ-012 fifo_level  output  5  number of buffered payloads, 0..FIFO_DEPTH.

Function
REQ-013 The FIFO SHALL be FIFO_DEPTH entries deep; payload_ready = (fifo_level != FIFO_DEPTH), combinational, with no bypass path.
REQ-014 A pop and a push in the same cycle SHALL leave fifo_level unchanged and preserve order.
REQ-015 A word SHALL be emitted only if the FIFO is non-empty at the clock edge; a payload accepted at edge k SHALL appear on data_out at edge k+1 at the earliest.
REQ-016 IDLE: data_valid=0, seq=0; SHALL go to FIRST when enable=1 and the FIFO is non-empty.
REQ-017 FIRST: emits a word with seq=0 and data_valid=1; next state is SEND if enable=1 and the FIFO is non-empty, HOLD if enable=1 and the FIFO is empty.
REQ-018 SEND: emits a word with the current seq, then seq = seq+1 mod 16 (4'hF wraps to 4'h0 without leaving SEND).
REQ-019 HOLD: data_valid=0, data_out and seq retained; SHALL return to SEND when the FIFO becomes non-empty.
REQ-020 enable=0 in any state SHALL force IDLE on the next edge and clear seq; no word is emitted in that cycle; buffered payloads are kept.
REQ-021 data_out SHALL hold its last value whenever data_valid=0.

Reset
REQ-022 On reset assertion, without waiting for a clock, the block SHALL drive: data_out=16'h0000, data_valid=0, state_out=4'b0001, seq=0, fifo_level=0, payload_ready=0.
REQ-023 Reset asserted mid-frame SHALL discard all FIFO contents and any in-flight word.
REQ-024 After reset deasserts, payload_ready SHALL be 1 and the first word of the next frame SHALL carry seq=0.

Configuration
REQ-025 Macro BUS_PKT_TX_ERR_INJ_EN defined: adds input inj_err[1:0], sampled on the emitting cycle.
  - inj_err[0]=1 replaces the header with ~HEADER.
  - inj_err[1]=1 emits seq+1 and advances seq by 2.
REQ-026 Macro BUS_PKT_TX_ERR_INJ_EN undefined: the inj_err port SHALL be absent and headers and sequence numbers are always correct.

Verification
REQ-027 Reset, then enable=1 and push 0xBA -> next edge data_out=16'hFBA0, data_valid=1, state_out=0010.
REQ-028 Push 0xBA, 0x0A, 0x10, 0x1F on consecutive cycles -> FBA0, F0A1, F102, F1F3 on consecutive cycles.
REQ-029 Push 17 payloads of 0x55 with enable=1 -> seq 0..F, then 17th word 16'hF550, state stays SEND.
REQ-030 enable=0, push 5 -> 4 accepted, payload_ready=0 at fifo_level=4, 5th held; set enable=1 -> 4 words with seq 0..3, then HOLD with data_valid=0.
REQ-031 Assert reset mid-stream between edges -> data_out=0, data_valid=0, state_out=0001, fifo_level=0 immediately; the next frame restarts at seq=0.
REQ-032 With BUS_PKT_TX_ERR_INJ_EN, inj_err=01 on payload 0xC9 at seq 3 -> data_out=16'h0C93; inj_err=10 at seq 4 -> seq 5 emitted, next word seq 6.
